lcd_timing_gen: RTL and testbench

LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

---
 rtl/lcd_timing_pkg.sv | 38 +++
 rtl/lcd_timing_gen_if.sv | 39 +++
 rtl/lcd_axis_cnt.sv | 25 ++
 rtl/lcd_timing_gen.sv | 161 ++++++++++++++++
 tb/tb_lcd_timing_gen.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_timing_pkg.sv
// Shared timing record and panel presets for the LCD timing generator.
// Presets use a fixed 16-bit field width; the generator narrows them to CNT_W.
package lcd_timing_pkg;

    localparam int PRESET_W = 16;

    typedef struct packed {
        logic [PRESET_W-1:0] h_sync;
        logic [PRESET_W-1:0] h_back;
        logic [PRESET_W-1:0] h_disp;
        logic [PRESET_W-1:0] h_front;
        logic [PRESET_W-1:0] v_sync;
        logic [PRESET_W-1:0] v_back;
        logic [PRESET_W-1:0] v_disp;
        logic [PRESET_W-1:0] v_front;
    } lcd_timing_t;

    localparam lcd_timing_t TIMING_480X272 = '{
        h_sync: 16'd41,  h_back: 16'd2,   h_disp: 16'd480,  h_front: 16'd2,
        v_sync: 16'd10,  v_back: 16'd2,   v_disp: 16'd272,  v_front: 16'd2
    };

    localparam lcd_timing_t TIMING_800X480 = '{
        h_sync: 16'd128, h_back: 16'd88,  h_disp: 16'd800,  h_front: 16'd40,
        v_sync: 16'd2,   v_back: 16'd33,  v_disp: 16'd480,  v_front: 16'd10
    };

    localparam lcd_timing_t TIMING_1024X600 = '{
        h_sync: 16'd20,  h_back: 16'd140, h_disp: 16'd1024, h_front: 16'd160,
        v_sync: 16'd3,   v_back: 16'd20,  v_disp: 16'd600,  v_front: 16'd12
    };

    localparam lcd_timing_t TIMING_1280X800 = '{
        h_sync: 16'd32,  h_back: 16'd80,  h_disp: 16'd1280, h_front: 16'd48,
        v_sync: 16'd6,   v_back: 16'd14,  v_disp: 16'd800,  v_front: 16'd3
    };

endpackage

// File: rtl/lcd_timing_gen_if.sv
// Configuration and panel-side signal bundle for lcd_timing_gen.
// Configuration: cfg_wr is a one-cycle strobe, no ready; fields are sampled with it.
interface lcd_timing_gen_if #(
    parameter int CNT_W = 12
);
    logic             run;
    logic             cfg_wr;
    logic [CNT_W-1:0] cfg_h_sync;
    logic [CNT_W-1:0] cfg_h_back;
    logic [CNT_W-1:0] cfg_h_disp;
    logic [CNT_W-1:0] cfg_h_front;
    logic [CNT_W-1:0] cfg_v_sync;
    logic [CNT_W-1:0] cfg_v_back;
    logic [CNT_W-1:0] cfg_v_disp;
    logic [CNT_W-1:0] cfg_v_front;
    logic             cfg_err;
    logic             lcd_hs;
    logic             lcd_vs;
    logic             lcd_de;
    logic             data_req;
    logic [CNT_W-1:0] pixel_xpos;
    logic [CNT_W-1:0] pixel_ypos;
    logic             frame_start;
    logic             line_start;

    modport master (
        output run, cfg_wr, cfg_h_sync, cfg_h_back, cfg_h_disp, cfg_h_front,
               cfg_v_sync, cfg_v_back, cfg_v_disp, cfg_v_front,
        input  cfg_err, lcd_hs, lcd_vs, lcd_de, data_req, pixel_xpos, pixel_ypos,
               frame_start, line_start
    );

    modport slave (
        input  run, cfg_wr, cfg_h_sync, cfg_h_back, cfg_h_disp, cfg_h_front,
               cfg_v_sync, cfg_v_back, cfg_v_disp, cfg_v_front,
        output cfg_err, lcd_hs, lcd_vs, lcd_de, data_req, pixel_xpos, pixel_ypos,
               frame_start, line_start
    );
endinterface

// File: rtl/lcd_axis_cnt.sv
// Wrapping axis counter: counts 0..last while enabled, flags the wrap cycle.
module lcd_axis_cnt #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic [W-1:0] count,
    output logic         wrap
);
    // >= rather than == keeps the counter bounded if last ever shrinks under it
    assign wrap = en && (count >= last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + W'(1);
        end
    end
endmodule

// File: rtl/lcd_timing_gen.sv
// Programmable LCD panel timing generator with double-buffered configuration
// that only takes effect on a frame boundary (or immediately while stopped).
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int CNT_W    = 12,
    parameter int REQ_LEAD = 1,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input logic            lcd_clk,
    input logic            sys_rst_n,
    lcd_timing_gen_if.slave bus
);
    localparam int SW = CNT_W + 2;
    localparam logic [SW-1:0] MAX_TOTAL = {2'b00, {CNT_W{1'b1}}};

    typedef struct packed {
        logic [CNT_W-1:0] h_sync;
        logic [CNT_W-1:0] h_back;
        logic [CNT_W-1:0] h_disp;
        logic [CNT_W-1:0] h_front;
        logic [CNT_W-1:0] v_sync;
        logic [CNT_W-1:0] v_back;
        logic [CNT_W-1:0] v_disp;
        logic [CNT_W-1:0] v_front;
    } timing_t;

    function automatic timing_t from_preset(input lcd_timing_t p);
        timing_t t;
        t.h_sync  = CNT_W'(p.h_sync);
        t.h_back  = CNT_W'(p.h_back);
        t.h_disp  = CNT_W'(p.h_disp);
        t.h_front = CNT_W'(p.h_front);
        t.v_sync  = CNT_W'(p.v_sync);
        t.v_back  = CNT_W'(p.v_back);
        t.v_disp  = CNT_W'(p.v_disp);
        t.v_front = CNT_W'(p.v_front);
        return t;
    endfunction

    localparam timing_t DEFAULT_TIMING = from_preset(TIMING_480X272);

    timing_t          cfg_in, pend_q, act_q;
    logic [SW-1:0]    h_lead_in, h_total_in, v_total_in;
    logic             cfg_ok, cfg_err_q;
    logic [CNT_W-1:0] h_cnt, v_cnt, h_last, v_last;
    logic             h_wrap, v_wrap;
    logic [CNT_W-1:0] h_act_start, h_act_end, h_req_start, h_req_end;
    logic [CNT_W-1:0] v_act_start, v_act_end;
    logic             h_in_act, h_in_req, v_in_act;

    assign cfg_in.h_sync  = bus.cfg_h_sync;
    assign cfg_in.h_back  = bus.cfg_h_back;
    assign cfg_in.h_disp  = bus.cfg_h_disp;
    assign cfg_in.h_front = bus.cfg_h_front;
    assign cfg_in.v_sync  = bus.cfg_v_sync;
    assign cfg_in.v_back  = bus.cfg_v_back;
    assign cfg_in.v_disp  = bus.cfg_v_disp;
    assign cfg_in.v_front = bus.cfg_v_front;

    // Sums are taken two bits wider so an oversized total cannot alias small
    assign h_lead_in  = SW'(cfg_in.h_sync) + SW'(cfg_in.h_back);
    assign h_total_in = h_lead_in + SW'(cfg_in.h_disp) + SW'(cfg_in.h_front);
    assign v_total_in = SW'(cfg_in.v_sync) + SW'(cfg_in.v_back)
                      + SW'(cfg_in.v_disp) + SW'(cfg_in.v_front);
    assign cfg_ok = (cfg_in.h_sync != '0) && (cfg_in.h_disp != '0)
                 && (cfg_in.v_sync != '0) && (cfg_in.v_disp != '0)
                 && (h_lead_in >= SW'(REQ_LEAD))
                 && (h_total_in <= MAX_TOTAL) && (v_total_in <= MAX_TOTAL);

    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pend_q    <= DEFAULT_TIMING;
            cfg_err_q <= 1'b0;
        end else if (bus.cfg_wr) begin
            if (cfg_ok) begin
                pend_q    <= cfg_in;
                cfg_err_q <= 1'b0;
            end else begin
                cfg_err_q <= 1'b1;
            end
        end
    end

    // v_wrap only fires on the last pixel of the last line: the frame boundary
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            act_q <= DEFAULT_TIMING;
        end else if (!bus.run || v_wrap) begin
            act_q <= pend_q;
        end
    end

    assign h_act_start = act_q.h_sync + act_q.h_back;
    assign h_act_end   = h_act_start + act_q.h_disp;
    assign h_req_start = h_act_start - CNT_W'(REQ_LEAD);
    assign h_req_end   = h_req_start + act_q.h_disp;
    assign h_last      = h_act_end + act_q.h_front - CNT_W'(1);
    assign v_act_start = act_q.v_sync + act_q.v_back;
    assign v_act_end   = v_act_start + act_q.v_disp;
    assign v_last      = v_act_end + act_q.v_front - CNT_W'(1);

    lcd_axis_cnt #(.W(CNT_W)) u_h_cnt (
        .clk(lcd_clk), .rst_n(sys_rst_n), .clr(!bus.run), .en(bus.run),
        .last(h_last), .count(h_cnt), .wrap(h_wrap)
    );

    lcd_axis_cnt #(.W(CNT_W)) u_v_cnt (
        .clk(lcd_clk), .rst_n(sys_rst_n), .clr(!bus.run), .en(h_wrap),
        .last(v_last), .count(v_cnt), .wrap(v_wrap)
    );

    assign h_in_act = (h_cnt >= h_act_start) && (h_cnt < h_act_end);
    assign h_in_req = (h_cnt >= h_req_start) && (h_cnt < h_req_end);
    assign v_in_act = (v_cnt >= v_act_start) && (v_cnt < v_act_end);

    logic             hs_q, vs_q, de_q, req_q, fs_q, ls_q;
    logic [CNT_W-1:0] xpos_q, ypos_q;

    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hs_q   <= ~HS_POL;
            vs_q   <= ~VS_POL;
            de_q   <= 1'b0;
            req_q  <= 1'b0;
            fs_q   <= 1'b0;
            ls_q   <= 1'b0;
            xpos_q <= '0;
            ypos_q <= '0;
        end else if (!bus.run) begin
            hs_q   <= ~HS_POL;
            vs_q   <= ~VS_POL;
            de_q   <= 1'b0;
            req_q  <= 1'b0;
            fs_q   <= 1'b0;
            ls_q   <= 1'b0;
            xpos_q <= '0;
            ypos_q <= '0;
        end else begin
            hs_q   <= (h_cnt < act_q.h_sync) ? HS_POL : ~HS_POL;
            vs_q   <= (v_cnt < act_q.v_sync) ? VS_POL : ~VS_POL;
            de_q   <= h_in_act && v_in_act;
            req_q  <= h_in_req && v_in_act;
            fs_q   <= (h_cnt == '0) && (v_cnt == '0);
            ls_q   <= (h_cnt == '0);
            xpos_q <= (h_in_req && v_in_act) ? h_cnt - h_req_start : '0;
            ypos_q <= (h_in_req && v_in_act) ? v_cnt - v_act_start : '0;
        end
    end

    assign bus.cfg_err     = cfg_err_q;
    assign bus.lcd_hs      = hs_q;
    assign bus.lcd_vs      = vs_q;
    assign bus.lcd_de      = de_q;
    assign bus.data_req    = req_q;
    assign bus.pixel_xpos  = xpos_q;
    assign bus.pixel_ypos  = ypos_q;
    assign bus.frame_start = fs_q;
    assign bus.line_start  = ls_q;
endmodule

// File: tb/tb_lcd_timing_gen.sv
// Scoreboard bench for lcd_timing_gen: a frame-position reference model predicts
// every registered output cycle; a negedge monitor pops and compares.
module tb_lcd_timing_gen;
    localparam int CNT_W    = 12;
    localparam int REQ_LEAD = 3;
    localparam bit HS_POL   = 1'b0;
    localparam bit VS_POL   = 1'b1;
    localparam int OW       = 7 + 2 * CNT_W;

    typedef struct {
        int hs; int hb; int hd; int hf;
        int vs; int vb; int vd; int vf;
    } tim_t;

    localparam tim_t DEF_T   = '{41, 2, 480, 2, 10, 2, 272, 2};
    localparam tim_t T800    = '{128, 88, 800, 40, 2, 33, 480, 10};

    logic lcd_clk;
    logic sys_rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    lcd_timing_gen_if #(.CNT_W(CNT_W)) bus ();

    lcd_timing_gen #(
        .CNT_W(CNT_W), .REQ_LEAD(REQ_LEAD), .HS_POL(HS_POL), .VS_POL(VS_POL)
    ) dut (
        .lcd_clk(lcd_clk), .sys_rst_n(sys_rst_n), .bus(bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        lcd_clk = 1'b0;
        forever #5 lcd_clk = ~lcd_clk;
    end

    // ---------------- reference model ----------------
    logic [OW-1:0] exp_q[$];
    tim_t m_act  = DEF_T;
    tim_t m_pend = DEF_T;
    int   m_pos  = 0;
    bit   m_err  = 1'b0;

    function automatic logic [OW-1:0] pack_out(bit err, bit hs, bit vs, bit de, bit req,
                                              bit fs, bit ls, int x, int y);
        logic [CNT_W-1:0] xv, yv;
        xv = x[CNT_W-1:0];
        yv = y[CNT_W-1:0];
        return {err, hs, vs, de, req, fs, ls, xv, yv};
    endfunction

    function automatic bit cfg_valid(tim_t t);
        int ht, vt;
        ht = t.hs + t.hb + t.hd + t.hf;
        vt = t.vs + t.vb + t.vd + t.vf;
        if (t.hs == 0 || t.hd == 0 || t.vs == 0 || t.vd == 0) return 1'b0;
        if (t.hs + t.hb < REQ_LEAD) return 1'b0;
        if (ht > (1 << CNT_W) - 1 || vt > (1 << CNT_W) - 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic tim_t read_cfg_pins();
        tim_t t;
        t.hs = int'(bus.cfg_h_sync);  t.hb = int'(bus.cfg_h_back);
        t.hd = int'(bus.cfg_h_disp);  t.hf = int'(bus.cfg_h_front);
        t.vs = int'(bus.cfg_v_sync);  t.vb = int'(bus.cfg_v_back);
        t.vd = int'(bus.cfg_v_disp);  t.vf = int'(bus.cfg_v_front);
        return t;
    endfunction

    always @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_act  = DEF_T;
            m_pend = DEF_T;
            m_pos  = 0;
            m_err  = 1'b0;
            exp_q.delete();
        end else begin
            tim_t c;
            bit   ok, wrapped, hs, vs, de, req, fs, ls;
            int   ht, vt, h, v, has, vas, x, y;
            c  = read_cfg_pins();
            ok = cfg_valid(c);
            if (bus.cfg_wr) m_err = !ok;
            ht  = m_act.hs + m_act.hb + m_act.hd + m_act.hf;
            vt  = m_act.vs + m_act.vb + m_act.vd + m_act.vf;
            h   = m_pos % ht;
            v   = m_pos / ht;
            has = m_act.hs + m_act.hb;
            vas = m_act.vs + m_act.vb;
            if (bus.run) begin
                hs  = (h < m_act.hs) ? HS_POL : !HS_POL;
                vs  = (v < m_act.vs) ? VS_POL : !VS_POL;
                de  = (h >= has && h < has + m_act.hd) && (v >= vas && v < vas + m_act.vd);
                req = (h + REQ_LEAD >= has && h + REQ_LEAD < has + m_act.hd)
                      && (v >= vas && v < vas + m_act.vd);
                fs  = (m_pos == 0);
                ls  = (h == 0);
                x   = req ? h + REQ_LEAD - has : 0;
                y   = req ? v - vas : 0;
            end else begin
                hs = !HS_POL; vs = !VS_POL; de = 0; req = 0; fs = 0; ls = 0; x = 0; y = 0;
            end
            exp_q.push_back(pack_out(m_err, hs, vs, de, req, fs, ls, x, y));
            wrapped = bus.run && (m_pos == ht * vt - 1);
            m_pos   = (!bus.run || wrapped) ? 0 : m_pos + 1;
            if (!bus.run || wrapped) m_act = m_pend;
            if (bus.cfg_wr && ok) m_pend = c;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    function automatic logic [OW-1:0] dut_vec();
        return {bus.cfg_err, bus.lcd_hs, bus.lcd_vs, bus.lcd_de, bus.data_req,
                bus.frame_start, bus.line_start, bus.pixel_xpos, bus.pixel_ypos};
    endfunction

    always @(negedge lcd_clk) begin
        if (sys_rst_n && exp_q.size() > 0) begin
            logic [OW-1:0] exp_v, got_v;
            exp_v = exp_q.pop_front();
            got_v = dut_vec();
            n_checks++;
            if (got_v !== exp_v) begin
                n_errors++;
                $display("FAIL out_vec t=%0t got=%h exp=%h (err,hs,vs,de,req,fs,ls,x,y)",
                         $time, got_v, exp_v);
            end
        end
    end

    task automatic check_idle(input string name);
        logic [OW-1:0] exp_v, got_v;
        exp_v = pack_out(1'b0, !HS_POL, !VS_POL, 0, 0, 0, 0, 0, 0);
        got_v = dut_vec();
        n_checks++;
        if (got_v !== exp_v) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", name, got_v, exp_v);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge lcd_clk);
    endtask

    task automatic write_cfg(input tim_t t);
        @(negedge lcd_clk);
        bus.cfg_h_sync  = t.hs[CNT_W-1:0];  bus.cfg_h_back  = t.hb[CNT_W-1:0];
        bus.cfg_h_disp  = t.hd[CNT_W-1:0];  bus.cfg_h_front = t.hf[CNT_W-1:0];
        bus.cfg_v_sync  = t.vs[CNT_W-1:0];  bus.cfg_v_back  = t.vb[CNT_W-1:0];
        bus.cfg_v_disp  = t.vd[CNT_W-1:0];  bus.cfg_v_front = t.vf[CNT_W-1:0];
        bus.cfg_wr      = 1'b1;
        @(negedge lcd_clk);
        bus.cfg_wr      = 1'b0;
    endtask

    task automatic drop_run(input int n);
        @(negedge lcd_clk);
        bus.run = 1'b0;
        wait_cycles(n);
        bus.run = 1'b1;
    endtask

    function automatic tim_t rand_cfg();
        tim_t t;
        t.hs = $urandom_range(1, 4);  t.hb = $urandom_range(0, 4);
        t.hd = $urandom_range(1, 12); t.hf = $urandom_range(0, 3);
        t.vs = $urandom_range(1, 3);  t.vb = $urandom_range(0, 3);
        t.vd = $urandom_range(1, 5);  t.vf = $urandom_range(0, 3);
        case ($urandom_range(0, 7))
            0: t.hd = 0;
            1: t.vs = 0;
            2: begin t.hs = 1; t.hb = 1; end
            default: ;
        endcase
        return t;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        tim_t a, b;
        sys_rst_n = 1'b1;
        bus.run = 1'b0;
        bus.cfg_wr = 1'b0;
        bus.cfg_h_sync = '0; bus.cfg_h_back = '0; bus.cfg_h_disp = '0; bus.cfg_h_front = '0;
        bus.cfg_v_sync = '0; bus.cfg_v_back = '0; bus.cfg_v_disp = '0; bus.cfg_v_front = '0;
        #1 sys_rst_n = 1'b0;
        #2 check_idle("reset_state");
        wait_cycles(3);
        sys_rst_n = 1'b1;
        wait_cycles(4);

        // default 480x272 timing, two full lines
        bus.run = 1'b1;
        wait_cycles(1200);

        // rejected write (h_disp=0), then a valid 800x480 write mid-frame
        a = DEF_T; a.hd = 0;
        write_cfg(a);
        wait_cycles(100);
        write_cfg(T800);
        wait_cycles(300);
        drop_run(10);
        wait_cycles(2200);

        // small timing, then two writes before the wrap: the last one wins
        a = '{2, 3, 8, 2, 1, 2, 4, 1};
        write_cfg(a);
        drop_run(3);
        wait_cycles(250);
        a = '{3, 1, 6, 1, 2, 1, 3, 2};
        b = '{1, 4, 10, 3, 1, 1, 5, 1};
        write_cfg(a);
        wait_cycles(5);
        write_cfg(b);
        wait_cycles(400);

        // oversized total and too-short lead are both rejected
        a = '{10, 2, 4090, 2, 1, 1, 2, 1};
        write_cfg(a);
        wait_cycles(20);
        a = '{1, 1, 8, 2, 1, 1, 2, 1};
        write_cfg(a);
        wait_cycles(200);
        drop_run(10);
        wait_cycles(150);

        for (int it = 0; it < 24; it++) begin
            wait_cycles($urandom_range(0, 200));
            write_cfg(rand_cfg());
            wait_cycles($urandom_range(100, 500));
            if ($urandom_range(0, 2) == 0) drop_run($urandom_range(1, 12));
        end

        // asynchronous reset mid-frame, then restart on default timing
        @(posedge lcd_clk);
        #2 sys_rst_n = 1'b0;
        #1 check_idle("async_reset");
        wait_cycles(2);
        sys_rst_n = 1'b1;
        wait_cycles(600);

        wait_cycles(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
